// File: rtl/mem_arbiter_if.sv
// Bundle between the arbiter, its two CPU requesters (fetch and data) and the shared word RAM.
// The slave modport is the arbiter's view; master is the requester/RAM side.
interface mem_arbiter_if #(
  parameter int ADDR_W = 22
);
  logic              i_req;
  logic [31:0]       i_addr;
  logic              i_gnt;
  logic              i_rvalid;
  logic [31:0]       i_rdata;
  logic              i_err;

  logic              d_req;
  logic [31:0]       d_addr;
  logic [3:0]        d_wr_en;
  logic [31:0]       d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [31:0]       d_rdata;
  logic              d_err;

  logic [3:0]        ram_wen;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_addr, d_wr_en, d_wdata, ram_rdata,
    output i_gnt, i_rvalid, i_rdata, i_err,
    output d_gnt, d_rvalid, d_rdata, d_err,
    output ram_wen, ram_addr, ram_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_addr, d_wr_en, d_wdata, ram_rdata,
    input  i_gnt, i_rvalid, i_rdata, i_err,
    input  d_gnt, d_rvalid, d_rdata, d_err,
    input  ram_wen, ram_addr, ram_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port word RAM between instruction fetch and data ports.
// Grants are combinational; read data returns to the owning port exactly one cycle later.
module mem_arbiter #(
  parameter int ADDR_W = 22,
  parameter int WORDS  = 256
) (
  input logic          clk,
  input logic          rst_n,
  mem_arbiter_if.slave bus
);

  typedef enum logic {PRIO_I = 1'b0, PRIO_D = 1'b1} prio_t;
  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_I = 2'd1, OWN_D = 2'd2} owner_t;

  prio_t             prio_reg, prio_next;
  owner_t            owner_reg, owner_next;
  logic              oor_reg, oor_next;
  logic              d_err_reg, d_err_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;

  logic [ADDR_W-1:0] i_idx, d_idx;
  logic              i_in_range, d_in_range;
  logic              d_is_read;
  logic              i_gnt, d_gnt;
  logic              i_rvalid, d_rvalid;

  assign i_idx = bus.i_addr[ADDR_W+1:2];
  assign d_idx = bus.d_addr[ADDR_W+1:2];
  // Range is judged on the full word address so high bits never alias into the RAM.
  assign i_in_range = ({2'b00, bus.i_addr[31:2]} < 32'(WORDS));
  assign d_in_range = ({2'b00, bus.d_addr[31:2]} < 32'(WORDS));
  assign d_is_read  = (bus.d_wr_en == 4'b0000);

  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (rst_n) begin
      if (bus.i_req && (!bus.d_req || prio_reg == PRIO_I)) begin
        i_gnt = 1'b1;
      end else if (bus.d_req) begin
        d_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    prio_next  = prio_reg;
    owner_next = OWN_NONE;
    oor_next   = 1'b0;
    d_err_next = d_gnt && !d_in_range;
    addr_next  = addr_reg;
    // Priority only moves after a conflict, and always toward the side that lost.
    if (bus.i_req && bus.d_req && rst_n) begin
      prio_next = i_gnt ? PRIO_D : PRIO_I;
    end
    if (i_gnt) begin
      owner_next = OWN_I;
      oor_next   = !i_in_range;
      addr_next  = i_idx;
    end else if (d_gnt) begin
      addr_next = d_idx;
      if (d_is_read) begin
        owner_next = OWN_D;
        oor_next   = !d_in_range;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_reg  <= PRIO_I;
      owner_reg <= OWN_NONE;
      oor_reg   <= 1'b0;
      d_err_reg <= 1'b0;
      addr_reg  <= '0;
    end else begin
      prio_reg  <= prio_next;
      owner_reg <= owner_next;
      oor_reg   <= oor_next;
      d_err_reg <= d_err_next;
      addr_reg  <= addr_next;
    end
  end

  assign i_rvalid = rst_n && (owner_reg == OWN_I);
  assign d_rvalid = rst_n && (owner_reg == OWN_D);

  assign bus.i_gnt    = i_gnt;
  assign bus.d_gnt    = d_gnt;
  assign bus.i_rvalid = i_rvalid;
  assign bus.d_rvalid = d_rvalid;
  assign bus.i_err    = i_rvalid && oor_reg;
  assign bus.d_err    = rst_n && d_err_reg;
  assign bus.i_rdata  = (i_rvalid && !oor_reg) ? bus.ram_rdata : 32'h0;
  assign bus.d_rdata  = (d_rvalid && !oor_reg) ? bus.ram_rdata : 32'h0;

  // Idle cycles keep presenting the last address so the RAM port stays quiet.
  assign bus.ram_addr  = rst_n ? addr_next : '0;
  assign bus.ram_wdata = rst_n ? bus.d_wdata : 32'h0;
  assign bus.ram_wen   = (d_gnt && d_in_range) ? bus.d_wr_en : 4'b0000;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural single-port RAM (registered read).
`timescale 1ns/1ps
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic init_mem = 1'b1;
  int   n_cmp = 0;
  int   n_fail = 0;

  logic [31:0] mem [0:255];

  mem_arbiter_if #(.ADDR_W(22)) bus ();

  mem_arbiter #(.ADDR_W(22), .WORDS(256)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (init_mem) begin
      for (int k = 0; k < 256; k++) mem[k] <= 32'hA000_0000 + 32'(k);
      mem[0] <= 32'hFFFF_FFFF;
      mem[2] <= 32'h0000_0013;
    end else begin
      for (int b = 0; b < 4; b++)
        if (bus.ram_wen[b]) mem[bus.ram_addr[7:0]][8*b +: 8] <= bus.ram_wdata[8*b +: 8];
    end
    bus.ram_rdata <= mem[bus.ram_addr[7:0]];
  end

  task automatic idle_inputs();
    bus.i_req = 1'b0; bus.i_addr = 32'h0;
    bus.d_req = 1'b0; bus.d_addr = 32'h0; bus.d_wr_en = 4'b0000; bus.d_wdata = 32'h0;
  endtask

  // Move to just after the next rising edge, where new inputs are driven.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    idle_inputs();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.i_req = 1'b1; bus.i_addr = 32'h8;
    bus.d_req = 1'b1; bus.d_addr = 32'h4; bus.d_wr_en = 4'b1111; bus.d_wdata = 32'h1234_5678;
    #2;
    n_cmp++; if (bus.i_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_i_gnt got=%b exp=0", bus.i_gnt); end
    n_cmp++; if (bus.d_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_d_gnt got=%b exp=0", bus.d_gnt); end
    n_cmp++; if (bus.ram_wen !== 4'b0) begin n_fail++; $display("FAIL reset_ram_wen got=%b exp=0", bus.ram_wen); end
    n_cmp++; if (bus.ram_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_ram_wdata got=%h exp=0", bus.ram_wdata); end
    n_cmp++; if (bus.ram_addr !== 22'h0) begin n_fail++; $display("FAIL reset_ram_addr got=%h exp=0", bus.ram_addr); end
    n_cmp++; if ({bus.i_rvalid, bus.d_rvalid, bus.i_err, bus.d_err} !== 4'b0) begin n_fail++; $display("FAIL reset_flags got=%b exp=0000", {bus.i_rvalid, bus.d_rvalid, bus.i_err, bus.d_err}); end
    n_cmp++; if ({bus.i_rdata, bus.d_rdata} !== 64'h0) begin n_fail++; $display("FAIL reset_rdata got=%h exp=0", {bus.i_rdata, bus.d_rdata}); end
    $display("reset: outputs checked with both requests held");
    apply_reset();
  endtask

  task automatic test_single_fetch();
    cyc();
    bus.i_req = 1'b1; bus.i_addr = 32'h8;
    @(negedge clk);
    n_cmp++; if (bus.i_gnt !== 1'b1) begin n_fail++; $display("FAIL fetch_gnt got=%b exp=1", bus.i_gnt); end
    n_cmp++; if (bus.ram_addr !== 22'd2) begin n_fail++; $display("FAIL fetch_ram_addr got=%h exp=2", bus.ram_addr); end
    cyc();
    idle_inputs();
    @(negedge clk);
    n_cmp++; if (bus.i_rvalid !== 1'b1) begin n_fail++; $display("FAIL fetch_rvalid got=%b exp=1", bus.i_rvalid); end
    n_cmp++; if (bus.i_rdata !== 32'h0000_0013) begin n_fail++; $display("FAIL fetch_rdata got=%h exp=00000013", bus.i_rdata); end
    n_cmp++; if (bus.i_err !== 1'b0) begin n_fail++; $display("FAIL fetch_err got=%b exp=0", bus.i_err); end
    n_cmp++; if (bus.ram_addr !== 22'd2) begin n_fail++; $display("FAIL fetch_addr_hold got=%h exp=2", bus.ram_addr); end
    cyc();
    @(negedge clk);
    n_cmp++; if (bus.i_rvalid !== 1'b0 || bus.i_rdata !== 32'h0) begin n_fail++; $display("FAIL fetch_rvalid_drop got=%b/%h exp=0/0", bus.i_rvalid, bus.i_rdata); end
    $display("single fetch: addr=0x8 rdata=%h", 32'h13);
  endtask

  task automatic test_byte_store();
    cyc();
    bus.d_req = 1'b1; bus.d_addr = 32'h1; bus.d_wr_en = 4'b0010; bus.d_wdata = 32'h0000_0100;
    @(negedge clk);
    n_cmp++; if (bus.d_gnt !== 1'b1) begin n_fail++; $display("FAIL store_gnt got=%b exp=1", bus.d_gnt); end
    n_cmp++; if (bus.ram_wen !== 4'b0010) begin n_fail++; $display("FAIL store_wen got=%b exp=0010", bus.ram_wen); end
    n_cmp++; if (bus.ram_wdata !== 32'h0000_0100) begin n_fail++; $display("FAIL store_wdata got=%h exp=00000100", bus.ram_wdata); end
    cyc();
    idle_inputs();
    @(negedge clk);
    n_cmp++; if (bus.d_rvalid !== 1'b0 || bus.d_err !== 1'b0) begin n_fail++; $display("FAIL store_no_rvalid got=%b/%b exp=0/0", bus.d_rvalid, bus.d_err); end
    n_cmp++; if (mem[0] !== 32'hFFFF_01FF) begin n_fail++; $display("FAIL store_mem got=%h exp=FFFF01FF", mem[0]); end
    $display("byte store: addr=0x1 wen=0010 mem0=%h", mem[0]);
  endtask

  task automatic test_out_of_range();
    cyc();
    bus.d_req = 1'b1; bus.d_addr = 32'h400; bus.d_wr_en = 4'b1111; bus.d_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    n_cmp++; if (bus.d_gnt !== 1'b1) begin n_fail++; $display("FAIL oor_wr_gnt got=%b exp=1", bus.d_gnt); end
    n_cmp++; if (bus.ram_wen !== 4'b0000) begin n_fail++; $display("FAIL oor_wr_wen got=%b exp=0000", bus.ram_wen); end
    cyc();
    bus.d_wr_en = 4'b0000;
    @(negedge clk);
    n_cmp++; if (bus.d_err !== 1'b1 || bus.d_rvalid !== 1'b0) begin n_fail++; $display("FAIL oor_wr_err got=%b/%b exp=1/0", bus.d_err, bus.d_rvalid); end
    n_cmp++; if (mem[0] !== 32'hFFFF_01FF) begin n_fail++; $display("FAIL oor_wr_mem got=%h exp=FFFF01FF", mem[0]); end
    cyc();
    bus.d_req = 1'b0;
    bus.i_req = 1'b1; bus.i_addr = 32'h1000_0000;
    @(negedge clk);
    n_cmp++; if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== 32'h0 || bus.d_err !== 1'b1) begin n_fail++; $display("FAIL oor_rd got=%b/%h/%b exp=1/0/1", bus.d_rvalid, bus.d_rdata, bus.d_err); end
    n_cmp++; if (bus.i_gnt !== 1'b1) begin n_fail++; $display("FAIL oor_fetch_gnt got=%b exp=1", bus.i_gnt); end
    cyc();
    idle_inputs();
    @(negedge clk);
    n_cmp++; if (bus.i_rvalid !== 1'b1 || bus.i_rdata !== 32'h0 || bus.i_err !== 1'b1) begin n_fail++; $display("FAIL oor_fetch got=%b/%h/%b exp=1/0/1", bus.i_rvalid, bus.i_rdata, bus.i_err); end
    n_cmp++; if (bus.d_err !== 1'b0) begin n_fail++; $display("FAIL oor_err_pulse got=%b exp=0", bus.d_err); end
    $display("out of range: write dropped, read and fetch return err with zero data");
  endtask

  task automatic test_store_load();
    cyc();
    bus.d_req = 1'b1; bus.d_addr = 32'h0; bus.d_wr_en = 4'b1111; bus.d_wdata = 32'h0102_0304;
    @(negedge clk);
    n_cmp++; if (bus.ram_wen !== 4'b1111) begin n_fail++; $display("FAIL sl_wen got=%b exp=1111", bus.ram_wen); end
    cyc();
    bus.d_wr_en = 4'b0000; bus.d_wdata = 32'h0;
    @(negedge clk);
    n_cmp++; if (bus.d_gnt !== 1'b1 || bus.ram_wen !== 4'b0) begin n_fail++; $display("FAIL sl_rd_gnt got=%b/%b exp=1/0000", bus.d_gnt, bus.ram_wen); end
    cyc();
    idle_inputs();
    @(negedge clk);
    n_cmp++; if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== 32'h0102_0304) begin n_fail++; $display("FAIL sl_rdata got=%b/%h exp=1/01020304", bus.d_rvalid, bus.d_rdata); end
    $display("store-then-load: addr=0x0 rdata=%h", bus.d_rdata);
  endtask

  task automatic test_conflict();
    logic [31:0] exp_word [0:1];
    exp_word[0] = 32'hA000_0004;
    exp_word[1] = 32'hA000_0008;
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      cyc();
      if (k < 4) begin
        bus.i_req = 1'b1; bus.i_addr = 32'h10;
        bus.d_req = 1'b1; bus.d_addr = 32'h20; bus.d_wr_en = 4'b0000;
      end else begin
        idle_inputs();
      end
      @(negedge clk);
      if (k < 4) begin
        n_cmp++; if (bus.i_gnt !== (k % 2 == 0) || bus.d_gnt !== (k % 2 == 1)) begin n_fail++; $display("FAIL conflict_gnt%0d got=%b%b exp=%b%b", k, bus.i_gnt, bus.d_gnt, (k % 2 == 0), (k % 2 == 1)); end
        n_cmp++; if (bus.ram_addr !== ((k % 2 == 0) ? 22'd4 : 22'd8)) begin n_fail++; $display("FAIL conflict_addr%0d got=%h", k, bus.ram_addr); end
      end
      if (k > 0) begin
        n_cmp++;
        if (bus.i_rvalid !== (k % 2 == 1) || bus.d_rvalid !== (k % 2 == 0) ||
            (bus.i_rdata | bus.d_rdata) !== exp_word[(k + 1) % 2]) begin
          n_fail++;
          $display("FAIL conflict_rvalid%0d got=%b%b %h exp=%b%b %h", k, bus.i_rvalid, bus.d_rvalid,
                   bus.i_rdata | bus.d_rdata, (k % 2 == 1), (k % 2 == 0), exp_word[(k + 1) % 2]);
        end
      end
      $display("conflict cycle %0d: i_gnt=%b d_gnt=%b", k, bus.i_gnt, bus.d_gnt);
    end
  endtask

  task automatic test_reset_mid_read();
    cyc();
    bus.i_req = 1'b1; bus.i_addr = 32'h8;
    bus.d_wdata = 32'h5555_AAAA;
    @(negedge clk);
    n_cmp++; if (bus.i_gnt !== 1'b1) begin n_fail++; $display("FAIL mid_gnt got=%b exp=1", bus.i_gnt); end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.i_gnt !== 1'b0 || bus.ram_addr !== 22'h0 || bus.ram_wdata !== 32'h0) begin n_fail++; $display("FAIL mid_outputs got=%b/%h/%h exp=0/0/0", bus.i_gnt, bus.ram_addr, bus.ram_wdata); end
    @(posedge clk);
    #1 idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++; if (bus.i_rvalid !== 1'b0 || bus.i_rdata !== 32'h0) begin n_fail++; $display("FAIL mid_no_rvalid got=%b/%h exp=0/0", bus.i_rvalid, bus.i_rdata); end
    cyc();
    bus.i_req = 1'b1; bus.i_addr = 32'h8;
    bus.d_req = 1'b1; bus.d_addr = 32'h20;
    @(negedge clk);
    n_cmp++; if (bus.i_gnt !== 1'b1 || bus.d_gnt !== 1'b0) begin n_fail++; $display("FAIL mid_prio got=%b%b exp=10", bus.i_gnt, bus.d_gnt); end
    cyc();
    bus.i_req = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.i_rvalid !== 1'b1 || bus.i_rdata !== 32'h0000_0013 || bus.d_gnt !== 1'b1) begin n_fail++; $display("FAIL mid_after got=%b/%h/%b exp=1/00000013/1", bus.i_rvalid, bus.i_rdata, bus.d_gnt); end
    $display("reset mid-read: no stale rvalid, first conflict went to fetch");
    cyc();
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 init_mem = 1'b0;
    test_reset();
    test_single_fetch();
    test_byte_store();
    test_out_of_range();
    test_store_load();
    test_conflict();
    test_reset_mid_read();
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
